line_clear_controller: RTL and testbench
========================================

Name: line_clear_controller

Overview:
Sequences the playfield row store after each piece lock. It scans every row bottom-up, removes full rows, compacts the surviving rows downward and zero-fills the vacated top rows. It then reports how many lines were cleared and keeps a running total. It sits between the game-state FSM (its falling_piece_lock drives start; new_tetromino is gated by busy) and the playfield row RAM. It is the sole writer to that RAM during a clear.

Parameters:
ROWS, 20, playfield rows; row 0 is top, ROWS-1 is bottom
COLS, 10, playfield columns (bits per row)
RW, $clog2(ROWS), row index width
CW, $clog2(ROWS+1), cleared-count width
TW, 16, lines_total width

Ports:
clk  in  1  system clock
rst_l  in  1  reset; asynchronous, active-low
start  in  1  begin a clear pass; sampled only in LC_IDLE
abort  in  1  game_end; returns to LC_IDLE next edge from any state
clear_total  in  1  zero lines_total (game_start)
rd_row  out  RW  playfield read address
rd_data  in  COLS  combinational read data for rd_row, same cycle
wr_en  out  1  playfield write strobe; commits at clk edge
wr_row  out  RW  write address
wr_data  out  COLS  write data
busy  out  1  high in every state except LC_IDLE
done  out  1  one-cycle pulse, pass complete
lines_cleared  out  CW  full rows removed by the last pass; valid from done until next start
lines_total  out  TW  cumulative lines, saturating

Behaviour:
- Reset: state LC_IDLE. Outputs busy, done, wr_en, lines_cleared and lines_total are 0. rd_row, wr_row and wr_data are 0.
- Registers: src and dst row pointers (RW bits each), cnt (CW bits).
- LC_IDLE: if start, load src=dst=ROWS-1, cnt=0, go to LC_SCAN.
- LC_SCAN: one row per cycle, so exactly ROWS cycles. rd_row=src.
  - If &rd_data (row full): cnt++, src--, no write.
  - Otherwise, if src!=dst: wr_en=1, wr_row=dst, wr_data=rd_data; then dst--, src--.
  - Otherwise (not full, src==dst): no write; dst--, src--.
  - On the cycle src==0, go to LC_FILL if the next cnt is nonzero, else go to LC_DONE.
- Invariant: dst>=src at all times. A write therefore never targets a row not yet read.
- LC_FILL: wr_en=1, wr_row=dst, wr_data=0, dst--. This runs exactly cnt cycles; after the write to row 0, go to LC_DONE.
- LC_DONE: done=1 for one cycle.
  - lines_cleared<=cnt.
  - lines_total<=min(lines_total+cnt, 2^TW-1).
  - Go to LC_IDLE.
- Latency: start sampled at edge E. done is high during cycle ROWS+cnt+1 after E. The next start is accepted the cycle after done.
- start while busy: ignored, not queued.
- abort: takes priority over all transitions. State goes to LC_IDLE, wr_en deasserts immediately (combinational on state), and no done is issued. lines_cleared and lines_total are unchanged; a partially compacted playfield is acceptable because the game is over.
- clear_total: lines_total<=0. It has priority over a same-cycle LC_DONE update.
- Pointer arithmetic is unsigned. The pointer decrement at row 0 is don't-care, because the state exits that cycle and no further use occurs.
- wr_en is never asserted outside LC_SCAN and LC_FILL.

Decomposition:
- GamePkg additions:
  - PLAYFIELD_ROWS=20 and PLAYFIELD_COLS=10, used as the parameter defaults.
  - line_clear_states_t {LC_IDLE, LC_SCAN, LC_FILL, LC_DONE}.
- Sub-module: the existing counter, instantiated for src and dst as down-counters with load=start accept and D=ROWS-1, and for cnt as an up-counter loaded with 0.
- The FSM and the saturating lines_total logic stay inline.

Test Plan:
- Empty playfield, start -> 20 SCAN cycles with no wr_en, no FILL, done on cycle 21, lines_cleared=0, lines_total=0.
- Row 19 full, row 18=0x001 -> write row19=0x001 (plus shifted upper rows), FILL writes row0=0; done on cycle 22; lines_cleared=1, lines_total=1.
- Rows 16-19 full (tetris), rows 15..0 patterned -> rows 19..4 hold old rows 15..0, rows 3..0 = 0, done on cycle 25, lines_cleared=4.
- Non-contiguous: rows 19 and 17 full, row 18=0x155 -> final row19=0x155, rows 1..0=0, lines_cleared=2.
- abort asserted on the 5th SCAN cycle -> next cycle state LC_IDLE, wr_en=0, busy=0, no done, lines_total unchanged; start pulsed while busy in another run -> ignored, single done.
- lines_total preset near 0xFFFE via repeated passes, then a 4-line clear -> lines_total=0xFFFF; clear_total coincident with done -> lines_total=0.

Source files
------------

// File: rtl/line_clear_controller_pkg.sv
// Shared definitions for the line-clear sequencer.
// Contents: playfield dimensions used as parameter defaults and the
// line_clear_states_t FSM state encoding.
package line_clear_controller_pkg;

  localparam int PLAYFIELD_ROWS = 20;
  localparam int PLAYFIELD_COLS = 10;

  typedef enum logic [1:0] {
    LC_IDLE,
    LC_SCAN,
    LC_FILL,
    LC_DONE
  } line_clear_states_t;

endpackage

// File: rtl/line_clear_controller_counter.sv
// Loadable up/down counter used for the row pointers and the cleared-row count.
// Ports:
//   clk, rst_l    clock, asynchronous active-low reset (clears q)
//   load, d       synchronous load of d; wins over en
//   en            count enable
//   up            1 = increment, 0 = decrement (modulo 2^W)
//   q             current count
module line_clear_controller_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)    q <= '0;
    else if (load) q <= d;
    else if (en)   q <= up ? q + W'(1) : q - W'(1);
  end

endmodule

// File: rtl/line_clear_controller.sv
// Line-clear sequencer for the playfield row RAM.
// After a piece lock it scans rows bottom-up, drops full rows, compacts the
// survivors downward, zero-fills the vacated top rows, then reports the count.
// Ports:
//   clk, rst_l            clock, asynchronous active-low reset
//   start                 begin a pass (only honoured while idle)
//   abort                 game end: back to idle next edge, no done
//   clear_total           zero lines_total (wins over a same-cycle update)
//   rd_row / rd_data      combinational playfield read port
//   wr_en/wr_row/wr_data  playfield write port, commits at clk edge
//   busy                  high whenever not idle
//   done                  one-cycle pass-complete pulse
//   lines_cleared         rows removed by the last pass
//   lines_total           saturating running total
module line_clear_controller
  import line_clear_controller_pkg::*;
#(
  parameter int ROWS = PLAYFIELD_ROWS,
  parameter int COLS = PLAYFIELD_COLS,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(ROWS + 1),
  parameter int TW   = 16
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            start,
  input  logic            abort,
  input  logic            clear_total,
  output logic [RW-1:0]   rd_row,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [RW-1:0]   wr_row,
  output logic [COLS-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   lines_cleared,
  output logic [TW-1:0]   lines_total
);

  line_clear_states_t state;

  logic [RW-1:0] src, dst;
  logic [CW-1:0] cnt, cnt_nxt, fin_cnt;
  logic          full, accept, in_scan, in_fill;
  logic          src_en, dst_en, cnt_en;
  logic [TW:0]   sum;
  logic [TW-1:0] tot_nxt;

  assign in_scan = (state == LC_SCAN);
  assign in_fill = (state == LC_FILL);
  assign full    = &rd_data;
  assign accept  = (state == LC_IDLE) && start && !abort;

  // src walks every row; dst only moves past rows that survive or get filled,
  // so dst >= src always holds and no write lands on an unread row.
  assign src_en = in_scan;
  assign dst_en = (in_scan && !full) || in_fill;
  assign cnt_en = in_scan && full;

  line_clear_controller_counter #(.W(RW)) u_src (
    .clk(clk), .rst_l(rst_l), .load(accept), .en(src_en), .up(1'b0),
    .d(RW'(ROWS - 1)), .q(src)
  );

  line_clear_controller_counter #(.W(RW)) u_dst (
    .clk(clk), .rst_l(rst_l), .load(accept), .en(dst_en), .up(1'b0),
    .d(RW'(ROWS - 1)), .q(dst)
  );

  line_clear_controller_counter #(.W(CW)) u_cnt (
    .clk(clk), .rst_l(rst_l), .load(accept), .en(cnt_en), .up(1'b1),
    .d('0), .q(cnt)
  );

  // Count including the row being scanned this cycle; lets the last SCAN
  // cycle decide FILL vs DONE and publish results on entry to DONE.
  assign cnt_nxt = cnt + CW'(full);
  assign fin_cnt = in_scan ? cnt_nxt : cnt;
  assign sum     = {1'b0, lines_total} + (TW+1)'(fin_cnt);
  assign tot_nxt = sum[TW] ? '1 : sum[TW-1:0];

  // Write port is a pure function of state so abort drops it at once.
  assign rd_row  = src;
  assign wr_en   = (in_scan && !full && (src != dst)) || in_fill;
  assign wr_row  = wr_en ? dst : '0;
  assign wr_data = (in_scan && wr_en) ? rd_data : '0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= LC_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      lines_total   <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= LC_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          LC_IDLE: if (start) begin
            state <= LC_SCAN;
            busy  <= 1'b1;
          end
          LC_SCAN: if (src == '0) begin
            if (cnt_nxt != '0) begin
              state <= LC_FILL;
            end else begin
              state         <= LC_DONE;
              done          <= 1'b1;
              lines_cleared <= fin_cnt;
              lines_total   <= tot_nxt;
            end
          end
          LC_FILL: if (dst == '0) begin
            state         <= LC_DONE;
            done          <= 1'b1;
            lines_cleared <= fin_cnt;
            lines_total   <= tot_nxt;
          end
          LC_DONE: begin
            state <= LC_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= LC_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
      if (clear_total) lines_total <= '0;
    end
  end

endmodule

// File: tb/tb_line_clear_controller.sv
// Randomized + directed bench for line_clear_controller. A behavioural model
// computes each pass's result by filtering the row list; the playfield RAM is
// modelled here and compared row by row after every pass.
module tb_line_clear_controller;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(ROWS + 1);
  localparam int TW   = 8;  // narrow total so saturation is reachable quickly
  localparam int MAXT = (1 << TW) - 1;
  localparam logic [COLS-1:0] ALL1 = {COLS{1'b1}};

  logic            clk = 1'b0;
  logic            rst_l, start, abort, clear_total;
  logic [RW-1:0]   rd_row, wr_row;
  logic [COLS-1:0] rd_data, wr_data;
  logic            wr_en, busy, done;
  logic [CW-1:0]   lines_cleared;
  logic [TW-1:0]   lines_total;

  line_clear_controller #(.ROWS(ROWS), .COLS(COLS), .TW(TW)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .abort(abort),
    .clear_total(clear_total), .rd_row(rd_row), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .busy(busy),
    .done(done), .lines_cleared(lines_cleared), .lines_total(lines_total)
  );

  always #5 clk = ~clk;

  // Playfield RAM: bulk preload from img, otherwise DUT writes.
  logic [COLS-1:0] pf  [ROWS];
  logic [COLS-1:0] img [ROWS];
  logic            ld;
  int              wr_cnt = 0;
  int              bad_wr = 0;

  always_comb rd_data = (int'(rd_row) < ROWS) ? pf[rd_row] : '0;

  always @(posedge clk) begin
    if (ld) begin
      for (int r = 0; r < ROWS; r++) pf[r] <= img[r];
    end else if (wr_en) begin
      if (int'(wr_row) < ROWS) pf[wr_row] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (wr_en && !busy) bad_wr <= bad_wr + 1;

  int n_chk = 0;
  int n_err = 0;
  int tot   = 0;
  int last_clr = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_pf();
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic img_rand(input int pct_full);
    for (int r = 0; r < ROWS; r++)
      img[r] = ($urandom_range(0, 99) < pct_full) ? ALL1
             : COLS'($urandom_range(0, (1 << COLS) - 2));
  endtask

  task automatic img_full_bottom(input int n);
    for (int r = 0; r < ROWS; r++) img[r] = (r >= ROWS - n) ? ALL1 : '0;
  endtask

  // One pass: model result, drive start, measure latency, compare everything.
  task automatic run_pass(input string name, input bit busy_start, input bit clr_at_done);
    logic [COLS-1:0] exp_pf [ROWS];
    int exp_cnt, exp_wr, d, lat, w0, extra;
    exp_cnt = 0; exp_wr = 0; d = ROWS - 1;
    for (int r = 0; r < ROWS; r++) exp_pf[r] = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (img[r] == ALL1) exp_cnt++;
      else begin
        exp_pf[d] = img[r];
        if (d != r) exp_wr++;
        d--;
      end
    end
    exp_wr += exp_cnt;
    tot = clr_at_done ? 0 : ((tot + exp_cnt > MAXT) ? MAXT : tot + exp_cnt);

    load_pf();
    w0 = wr_cnt; lat = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = busy_start && (k == 5);
      clear_total = clr_at_done && (k >= ROWS + exp_cnt) && (k <= ROWS + exp_cnt + 1);
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    @(negedge clk); clear_total = 1'b0;
    chk({name, ".latency"}, lat, ROWS + exp_cnt + 1);
    chk({name, ".cleared"}, int'(lines_cleared), exp_cnt);
    chk({name, ".total"}, int'(lines_total), tot);
    chk({name, ".writes"}, wr_cnt - w0, exp_wr);
    chk({name, ".busy_after"}, int'(busy), 0);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("%s.row%0d", name, r), int'(pf[r]), int'(exp_pf[r]));
    extra = 0;
    for (int k = 0; k < ROWS + 5; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({name, ".extra_done"}, extra, 0);
    last_clr = exp_cnt;
  endtask

  initial begin
    int dn;
    rst_l = 1'b0; start = 1'b0; abort = 1'b0; clear_total = 1'b0; ld = 1'b0;
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    #12;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.wr_en", int'(wr_en), 0);
    chk("rst.cleared", int'(lines_cleared), 0);
    chk("rst.total", int'(lines_total), 0);
    chk("rst.rd_row", int'(rd_row), 0);
    chk("rst.wr_row", int'(wr_row), 0);
    chk("rst.wr_data", int'(wr_data), 0);
    @(negedge clk); rst_l = 1'b1;

    // Directed cases.
    run_pass("empty", 1'b0, 1'b0);
    img_full_bottom(1); img[18] = 10'h001;
    run_pass("single", 1'b0, 1'b0);
    for (int r = 0; r < ROWS; r++) img[r] = COLS'((r * 73 + 5) % 1023);
    for (int r = 16; r < ROWS; r++) img[r] = ALL1;
    run_pass("tetris", 1'b0, 1'b0);
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[19] = ALL1; img[18] = 10'h155; img[17] = ALL1;
    run_pass("gap", 1'b0, 1'b0);

    // start pulsed mid-pass must be ignored.
    img_rand(30);
    run_pass("busy_start", 1'b1, 1'b0);

    // Abort on the 5th SCAN cycle.
    img_full_bottom(3);
    load_pf();
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 5; k++) begin @(negedge clk); start = 1'b0; end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.wr_en", int'(wr_en), 0);
    dn = int'(done);
    for (int k = 0; k < 40; k++) begin @(negedge clk); dn += int'(done); end
    chk("abort.no_done", dn, 0);
    chk("abort.total", int'(lines_total), tot);
    chk("abort.cleared", int'(lines_cleared), last_clr);

    // Random passes.
    for (int i = 0; i < 20; i++) begin
      img_rand(int'($urandom_range(0, 60)));
      run_pass($sformatf("rnd%0d", i), 1'b0, 1'b0);
    end

    // Saturation: zero the total, climb to MAXT-1, then overflow.
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    run_pass("zero", 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      img_full_bottom(ROWS);
      run_pass($sformatf("climb%0d", i), 1'b0, 1'b0);
    end
    img_full_bottom(14);
    run_pass("near_max", 1'b0, 1'b0);
    chk("near_max.val", int'(lines_total), MAXT - 1);
    img_full_bottom(4);
    run_pass("sat", 1'b0, 1'b0);
    chk("sat.val", int'(lines_total), MAXT);
    img_full_bottom(4);
    run_pass("sat_hold", 1'b0, 1'b0);
    img_full_bottom(3);
    run_pass("clr_at_done", 1'b0, 1'b1);
    chk("clr_at_done.val", int'(lines_total), 0);

    chk("wr_outside_busy", bad_wr, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
